// File: rtl/seq_pkg.sv
// seq_pkg: shared definitions for the frame sequencer.
//   state_t       - scheduler FSM states
//   FRAME_LEN_DEF - default words per frame
//   DATA_W_DEF    - default signed sample width
//   sample_t      - signed sample word at the default width
package seq_pkg;
  localparam int FRAME_LEN_DEF = 40;
  localparam int DATA_W_DEF    = 16;

  typedef logic signed [DATA_W_DEF-1:0] sample_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;
endpackage

// File: rtl/frame_bank.sv
// frame_bank: ping-pong frame storage, two banks of FRAME_LEN signed words.
//   clk, rst  - clock, synchronous active-high reset (clears data and flags)
//   we        - write strobe; wbank/wptr/wdata select bank, word and value
//   set_full  - qualifies a write as the last word, marking wbank full
//   clr_full  - releases bank rbank (frame retired)
//   rbank     - bank presented on rdata
//   full      - per-bank full flags
//   rdata     - combinational view of bank rbank
module frame_bank import seq_pkg::*; #(
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int DATA_W    = DATA_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        we,
  input  logic                        wbank,
  input  logic [$clog2(FRAME_LEN)-1:0] wptr,
  input  logic signed [DATA_W-1:0]    wdata,
  input  logic                        set_full,
  input  logic                        clr_full,
  input  logic                        rbank,
  output logic [1:0]                  full,
  output logic signed [DATA_W-1:0]    rdata [FRAME_LEN]
);
  logic signed [DATA_W-1:0] mem [2][FRAME_LEN];

  // Retire and fill-complete never target the same bank: a full bank
  // cannot be written, so both updates may land on one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++)
        for (int w = 0; w < FRAME_LEN; w++)
          mem[b][w] <= '0;
      full <= '0;
    end else begin
      if (we) mem[wbank][wptr] <= wdata;
      if (we && set_full) full[wbank] <= 1'b1;
      if (clr_full) full[rbank] <= 1'b0;
    end
  end

  always_comb begin
    for (int w = 0; w < FRAME_LEN; w++)
      rdata[w] = mem[rbank][w];
  end
endmodule

// File: rtl/frame_sequencer.sv
// frame_sequencer: collects streaming samples into ping-pong frames and
// issues each full frame to the recognition core, holding it until the core
// acks, reports a finished word, or the watchdog expires.
//   i_clk, i_rst_n     - clock; synchronous active-high reset
//   i_sample_valid/i_sample/o_sample_ready - sample stream handshake
//   i_flush            - discard the partially filled frame
//   o_core_next        - one-cycle frame-issue pulse
//   o_core_data        - frame in flight (bank[issue_bank])
//   i_core_next        - core frame ack
//   i_core_finished    - core word-complete pulse
//   o_word_done        - registered copy of a finished seen while waiting
//   o_busy             - frame in flight
//   o_frame_count/o_drop_count/o_timeout_count - saturating statistics
// Build option: define SEQ_STATS_EN to implement the statistics counters;
// otherwise they are removed and the three ports read 0.
module frame_sequencer import seq_pkg::*; #(
  parameter int FRAME_LEN   = FRAME_LEN_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = 4096,
  parameter int CNT_W       = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_sample_valid,
  input  logic signed [DATA_W-1:0] i_sample,
  output logic                     o_sample_ready,
  input  logic                     i_flush,
  output logic                     o_core_next,
  output logic signed [DATA_W-1:0] o_core_data [FRAME_LEN],
  input  logic                     i_core_next,
  input  logic                     i_core_finished,
  output logic                     o_word_done,
  output logic                     o_busy,
  output logic [CNT_W-1:0]         o_frame_count,
  output logic [CNT_W-1:0]         o_drop_count,
  output logic [CNT_W-1:0]         o_timeout_count
);
  localparam int PTR_W = $clog2(FRAME_LEN);
  localparam int TMR_W = $clog2(TIMEOUT_CYC);
  localparam logic [PTR_W-1:0] LAST    = PTR_W'(FRAME_LEN - 1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYC - 1);

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   ptr;
  logic [TMR_W-1:0]   timer;
  logic               fill_bank, issue_bank;
  logic [1:0]         full;
  logic               accept, retire, timed_out, word_done;

  assign o_sample_ready = !full[fill_bank];
  // Flush wins over a same-cycle sample.
  assign accept         = i_sample_valid && o_sample_ready && !i_flush;
  assign o_core_next    = (state == S_ISSUE);
  assign o_busy         = (state != S_IDLE);
  assign o_word_done    = word_done;

  frame_bank #(.FRAME_LEN(FRAME_LEN), .DATA_W(DATA_W)) u_bank (
    .clk      (i_clk),
    .rst      (i_rst_n),
    .we       (accept),
    .wbank    (fill_bank),
    .wptr     (ptr),
    .wdata    (i_sample),
    .set_full (ptr == LAST),
    .clr_full (retire),
    .rbank    (issue_bank),
    .full     (full),
    .rdata    (o_core_data)
  );

  // Fill pointer and bank select.
  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      ptr       <= '0;
      fill_bank <= 1'b0;
    end else if (i_flush) begin
      ptr <= '0;
    end else if (accept) begin
      if (ptr == LAST) begin
        ptr       <= '0;
        fill_bank <= ~fill_bank;
      end else begin
        ptr <= ptr + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      state      <= S_IDLE;
      timer      <= '0;
      issue_bank <= 1'b0;
      word_done  <= 1'b0;
    end else begin
      state     <= state_nxt;
      word_done <= (state == S_WAIT) && i_core_finished;
      if (state == S_ISSUE) timer <= '0;
      else if (state == S_WAIT) timer <= timer + TMR_W'(1);
      if (retire) issue_bank <= ~issue_bank;
    end
  end

  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    case (state)
      S_IDLE:  if (full[issue_bank]) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:
        if (i_core_next || i_core_finished || timer == TMR_MAX) begin
          retire    = 1'b1;
          state_nxt = S_IDLE;
        end
      default: state_nxt = S_IDLE;
    endcase
  end

  // A core response on the expiry cycle counts as a normal completion.
  assign timed_out = retire && !i_core_next && !i_core_finished;

`ifdef SEQ_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic [CNT_W-1:0] frame_cnt, drop_cnt, tmo_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      frame_cnt <= '0;
      drop_cnt  <= '0;
      tmo_cnt   <= '0;
    end else begin
      if (retire && frame_cnt != CNT_MAX) frame_cnt <= frame_cnt + CNT_W'(1);
      if (i_sample_valid && !o_sample_ready && drop_cnt != CNT_MAX)
        drop_cnt <= drop_cnt + CNT_W'(1);
      if (timed_out && tmo_cnt != CNT_MAX) tmo_cnt <= tmo_cnt + CNT_W'(1);
    end
  end

  assign o_frame_count   = frame_cnt;
  assign o_drop_count    = drop_cnt;
  assign o_timeout_count = tmo_cnt;
`else
  logic unused_stats;
  assign unused_stats    = timed_out;
  assign o_frame_count   = '0;
  assign o_drop_count    = '0;
  assign o_timeout_count = '0;
`endif
endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: directed self-checking bench for frame_sequencer.
// Counter expectations follow the SEQ_STATS_EN build option (0 when off).
module tb_frame_sequencer;
`ifdef SEQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               s_valid = 1'b0;
  logic signed [15:0] s_data = '0;
  logic               s_ready;
  logic               flush = 1'b0;
  logic               core_next;
  logic signed [15:0] core_data [40];
  logic               ack = 1'b0;
  logic               fin = 1'b0;
  logic               word_done, busy;
  logic [15:0]        frame_cnt, drop_cnt, tmo_cnt;

  int errors = 0;
  int checks = 0;

  frame_sequencer dut (
    .i_clk           (clk),
    .i_rst_n         (rst),
    .i_sample_valid  (s_valid),
    .i_sample        (s_data),
    .o_sample_ready  (s_ready),
    .i_flush         (flush),
    .o_core_next     (core_next),
    .o_core_data     (core_data),
    .i_core_next     (ack),
    .i_core_finished (fin),
    .o_word_done     (word_done),
    .o_busy          (busy),
    .o_frame_count   (frame_cnt),
    .o_drop_count    (drop_cnt),
    .o_timeout_count (tmo_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; s_valid = 1'b0; flush = 1'b0; ack = 1'b0; fin = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic stream(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1; s_data = 16'(base + i);
      step();
    end
    s_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", s_ready); end
    checks++; if (core_next !== 1'b0) begin errors++; $display("FAIL reset_next: got %b want 0", core_next); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (word_done !== 1'b0) begin errors++; $display("FAIL reset_word_done: got %b want 0", word_done); end
    checks++; if (frame_cnt !== 16'd0 || drop_cnt !== 16'd0 || tmo_cnt !== 16'd0) begin errors++; $display("FAIL reset_counts: got %0d/%0d/%0d want 0/0/0", frame_cnt, drop_cnt, tmo_cnt); end
    checks++; if (core_data[0] !== 16'sd0 || core_data[39] !== 16'sd0) begin errors++; $display("FAIL reset_data: got %0d/%0d want 0/0", core_data[0], core_data[39]); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    stream(1, 40);
    checks++; if (core_next !== 1'b0) begin errors++; $display("FAIL basic_next_early: got %b want 0", core_next); end
    step();
    checks++; if (core_next !== 1'b1) begin errors++; $display("FAIL basic_next: got %b want 1", core_next); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy); end
    checks++; if (core_data[0] !== 16'sd1) begin errors++; $display("FAIL basic_word0: got %0d want 1", core_data[0]); end
    checks++; if (core_data[39] !== 16'sd40) begin errors++; $display("FAIL basic_word39: got %0d want 40", core_data[39]); end
    step();
    checks++; if (core_next !== 1'b0) begin errors++; $display("FAIL basic_next_pulse: got %b want 0", core_next); end
    repeat (4) step();
    ack = 1'b1; step(); ack = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_retire_busy: got %b want 0", busy); end
    checks++; if (frame_cnt !== (STATS ? 16'd1 : 16'd0)) begin errors++; $display("FAIL basic_frame_cnt: got %0d want %0d", frame_cnt, STATS ? 1 : 0); end
  endtask

  task automatic test_timeout();
    int n, acc, issues, cyc;
    int issued [3];
    logic rdy;
    do_reset();
    n = 1; acc = 0; issues = 0; cyc = 0;
    for (int c = 0; c < 120; c++) begin
      s_valid = 1'b1; s_data = 16'(n); rdy = s_ready;
      step();
      if (rdy) begin n++; acc++; end
      if (core_next === 1'b1 && issues < 3) begin issued[issues] = int'(core_data[0]); issues++; end
    end
    s_valid = 1'b0;
    checks++; if (acc != 80) begin errors++; $display("FAIL tmo_accepted: got %0d want 80", acc); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL tmo_ready_stall: got %b want 0", s_ready); end
    checks++; if (drop_cnt !== (STATS ? 16'd40 : 16'd0)) begin errors++; $display("FAIL tmo_drop_cnt: got %0d want %0d", drop_cnt, STATS ? 40 : 0); end
    while (!(issues == 3 && busy == 1'b0) && cyc < 15000) begin
      s_valid = (n <= 120) && s_ready; s_data = 16'(n); rdy = s_valid;
      step();
      if (rdy) n++;
      if (core_next === 1'b1 && issues < 3) begin issued[issues] = int'(core_data[0]); issues++; end
      cyc++;
    end
    s_valid = 1'b0;
    checks++; if (cyc >= 15000) begin errors++; $display("FAIL tmo_budget: got %0d issues want 3 retired", issues); end
    checks++; if (issued[0] != 1 || issued[1] != 41 || issued[2] != 81) begin errors++; $display("FAIL tmo_order: got %0d,%0d,%0d want 1,41,81", issued[0], issued[1], issued[2]); end
    checks++; if (tmo_cnt !== (STATS ? 16'd3 : 16'd0)) begin errors++; $display("FAIL tmo_count: got %0d want %0d", tmo_cnt, STATS ? 3 : 0); end
    checks++; if (frame_cnt !== (STATS ? 16'd3 : 16'd0)) begin errors++; $display("FAIL tmo_frame_cnt: got %0d want %0d", frame_cnt, STATS ? 3 : 0); end
    checks++; if (drop_cnt !== (STATS ? 16'd40 : 16'd0)) begin errors++; $display("FAIL tmo_drop_final: got %0d want %0d", drop_cnt, STATS ? 40 : 0); end
  endtask

  task automatic test_finished();
    do_reset();
    fin = 1'b1; step(); fin = 1'b0;
    checks++; if (word_done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL fin_idle_ignored: got done=%b busy=%b want 0/0", word_done, busy); end
    stream(200, 40);
    step(); step();
    checks++; if (busy !== 1'b1 || core_data[0] !== 16'sd200) begin errors++; $display("FAIL fin_inflight: got busy=%b w0=%0d want 1/200", busy, core_data[0]); end
    fin = 1'b1; step(); fin = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fin_retire: got %b want 0", busy); end
    checks++; if (word_done !== 1'b1) begin errors++; $display("FAIL fin_word_done: got %b want 1", word_done); end
    checks++; if (frame_cnt !== (STATS ? 16'd1 : 16'd0) || tmo_cnt !== 16'd0) begin errors++; $display("FAIL fin_counts: got %0d/%0d want %0d/0", frame_cnt, tmo_cnt, STATS ? 1 : 0); end
    step();
    checks++; if (word_done !== 1'b0) begin errors++; $display("FAIL fin_word_done_pulse: got %b want 0", word_done); end
  endtask

  task automatic test_flush();
    do_reset();
    stream(500, 25);
    s_valid = 1'b1; s_data = 16'sd999; flush = 1'b1;
    step();
    flush = 1'b0; s_valid = 1'b0;
    checks++; if (s_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL flush_state: got ready=%b busy=%b want 1/0", s_ready, busy); end
    stream(100, 40);
    checks++; if (core_next !== 1'b0) begin errors++; $display("FAIL flush_next_early: got %b want 0", core_next); end
    step();
    checks++; if (core_next !== 1'b1) begin errors++; $display("FAIL flush_next: got %b want 1", core_next); end
    checks++; if (core_data[0] !== 16'sd100 || core_data[1] !== 16'sd101) begin errors++; $display("FAIL flush_word0: got %0d,%0d want 100,101", core_data[0], core_data[1]); end
    checks++; if (core_data[39] !== 16'sd139) begin errors++; $display("FAIL flush_word39: got %0d want 139", core_data[39]); end
  endtask

  task automatic test_ack_at_limit();
    do_reset();
    stream(1, 40);
    step(); step();
    repeat (4095) step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL limit_busy: got %b want 1", busy); end
    ack = 1'b1; step(); ack = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL limit_retire: got %b want 0", busy); end
    checks++; if (tmo_cnt !== 16'd0) begin errors++; $display("FAIL limit_tmo_cnt: got %0d want 0", tmo_cnt); end
    checks++; if (frame_cnt !== (STATS ? 16'd1 : 16'd0)) begin errors++; $display("FAIL limit_frame_cnt: got %0d want %0d", frame_cnt, STATS ? 1 : 0); end
  endtask

  task automatic test_reset_in_wait();
    int seen;
    do_reset();
    stream(1, 80);
    checks++; if (s_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL rw_pre: got ready=%b busy=%b want 0/1", s_ready, busy); end
    rst = 1'b1; step(); rst = 1'b0;
    checks++; if (busy !== 1'b0 || s_ready !== 1'b1) begin errors++; $display("FAIL rw_state: got busy=%b ready=%b want 0/1", busy, s_ready); end
    checks++; if (core_next !== 1'b0 || core_data[0] !== 16'sd0) begin errors++; $display("FAIL rw_outputs: got next=%b w0=%0d want 0/0", core_next, core_data[0]); end
    seen = 0;
    repeat (6) begin step(); if (core_next !== 1'b0 || word_done !== 1'b0) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL rw_no_issue: got %0d pulse cycles want 0", seen); end
    stream(300, 40);
    step();
    checks++; if (core_next !== 1'b1 || core_data[0] !== 16'sd300) begin errors++; $display("FAIL rw_new_frame: got next=%b w0=%0d want 1/300", core_next, core_data[0]); end
    checks++; if (core_data[39] !== 16'sd339) begin errors++; $display("FAIL rw_word39: got %0d want 339", core_data[39]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_finished();
    test_flush();
    test_ack_at_limit();
    test_reset_in_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
